// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to instruction memory
// and produces the IF/ID register, with redirect squash, stall hold and bubble insertion.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_if_stall,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_pcindex,
    input  logic [31:0] id_if_rega,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    input  logic        mem_if_ack,
    input  logic [31:0] mem_if_data,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] daddr_reg;
    logic [31:0] buf_instr_reg;
    logic [31:0] buf_nextpc_reg;
    logic [31:0] instr_reg;
    logic [31:0] nextpc_reg;

    logic        redir;
    logic [31:0] target;
    logic [31:0] pc_inc;

    // A stalled Decode cannot redirect: its selpcsource belongs to an instruction still held.
    assign redir  = id_if_selpcsource & ~is_if_stall;
    assign pc_inc = pc_reg + 32'd1;

    always_comb begin
        target = id_if_pcimd2ext;
        case (id_if_selpctype)
            2'b00:   target = id_if_pcimd2ext;
            2'b01:   target = id_if_pcindex;
            2'b10:   target = id_if_rega;
            default: target = EXC_VECTOR;
        endcase
    end

    assign if_mem_req    = (state_reg != HOLD) & ~reset;
    assign if_mem_addr   = (state_reg == DISCARD) ? daddr_reg : pc_reg;
    assign if_id_instruc = instr_reg;
    assign if_id_nextpc  = nextpc_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            instr_reg  <= NOP_INSTR;
            nextpc_reg <= 32'd0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (mem_if_ack) begin
                        if (redir) begin
                            pc_reg    <= target;
                            instr_reg <= NOP_INSTR;
                        end else if (!is_if_stall) begin
                            instr_reg  <= mem_if_data;
                            nextpc_reg <= pc_inc;
                            pc_reg     <= pc_inc;
                        end else begin
                            buf_instr_reg  <= mem_if_data;
                            buf_nextpc_reg <= pc_inc;
                            pc_reg         <= pc_inc;
                            state_reg      <= HOLD;
                        end
                    end else if (redir) begin
                        // The request already in flight must still be retired, so remember its address.
                        daddr_reg <= pc_reg;
                        pc_reg    <= target;
                        instr_reg <= NOP_INSTR;
                        state_reg <= DISCARD;
                    end else if (!is_if_stall) begin
                        instr_reg <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        pc_reg    <= target;
                        instr_reg <= NOP_INSTR;
                        state_reg <= FETCH;
                    end else if (!is_if_stall) begin
                        instr_reg  <= buf_instr_reg;
                        nextpc_reg <= buf_nextpc_reg;
                        state_reg  <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redir) begin
                        pc_reg <= target;
                    end
                    if (!is_if_stall) begin
                        instr_reg <= NOP_INSTR;
                    end
                    if (mem_if_ack) begin
                        state_reg <= FETCH;
                    end
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model plus an in-order scoreboard of
// the instructions that must reach IF/ID.
`timescale 1ns/100ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_if_stall;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_pcindex;
    logic [31:0] id_if_rega;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_if_ack;
    logic [31:0] mem_if_data;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        mem_en;
    int unsigned mem_lat;
    int unsigned wait_cnt;
    logic        mon_en;
    logic        mon_stall;
    logic        mon_rst;
    logic [63:0] exp_q[$];
    logic [63:0] exp_item;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clock            (clk),
        .reset            (reset),
        .is_if_stall      (is_if_stall),
        .id_if_selpcsource(id_if_selpcsource),
        .id_if_selpctype  (id_if_selpctype),
        .id_if_pcimd2ext  (id_if_pcimd2ext),
        .id_if_pcindex    (id_if_pcindex),
        .id_if_rega       (id_if_rega),
        .if_mem_req       (if_mem_req),
        .if_mem_addr      (if_mem_addr),
        .mem_if_ack       (mem_if_ack),
        .mem_if_data      (mem_if_data),
        .if_id_instruc    (if_id_instruc),
        .if_id_nextpc     (if_id_nextpc)
    );

    // Instruction image: the two halves are complements, so a word is never the NOP encoding.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign mem_if_ack  = mem_en && if_mem_req && (wait_cnt >= mem_lat);
    assign mem_if_data = mem_word(if_mem_addr);

    always @(posedge clk) begin
        if (reset || !mem_en || mem_if_ack || !if_mem_req) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({mem_word(a), a + 32'd1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every unstalled, non-reset edge rewrites IF/ID; a non-NOP value there is a delivered instruction.
    always begin
        @(posedge clk);
        mon_stall = is_if_stall;
        mon_rst   = reset;
        #1;
        if (mon_en && !mon_stall && !mon_rst && if_id_instruc !== NOP_INSTR) begin
            if (exp_q.size() == 0) begin
                check_value("sb_extra", if_id_instruc, NOP_INSTR);
            end else begin
                exp_item = exp_q.pop_front();
                check_value("sb_instr", if_id_instruc, exp_item[63:32]);
                check_value("sb_nextpc", if_id_nextpc, exp_item[31:0]);
                $display("[TB] txn instr=%h nextpc=%h", if_id_instruc, if_id_nextpc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; is_if_stall = 1'b0; id_if_selpcsource = 1'b0; id_if_selpctype = 2'b00;
        id_if_pcimd2ext = '0; id_if_pcindex = '0; id_if_rega = '0;
        mem_en = 1'b1; mem_lat = 0; mon_en = 1'b1;

        // 1: streaming fetch, one instruction per cycle
        tick();
        check_value("rst_req", {31'd0, if_mem_req}, 32'd0);
        check_value("rst_instr", if_id_instruc, NOP_INSTR);
        check_value("rst_nextpc", if_id_nextpc, 32'd0);
        check_value("rst_addr", if_mem_addr, RESET_PC);
        for (int k = 0; k < 8; k++) push_exp(32'(k));
        reset = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            check_value("t1_addr", if_mem_addr, 32'(k));
            tick();
            check_value("t1_nextpc", if_id_nextpc, 32'(k + 1));
        end
        mem_en = 1'b0;
        tick();
        check_value("t1_drain", 32'(exp_q.size()), 32'd0);

        // 2: stall for three cycles while data returns
        is_if_stall = 1'b1; mem_en = 1'b1;
        push_exp(32'd8); push_exp(32'd9); push_exp(32'd10);
        #1;
        check_value("t2_addr", if_mem_addr, 32'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("t2_hold_req", {31'd0, if_mem_req}, 32'd0);
            check_value("t2_hold_instr", if_id_instruc, NOP_INSTR);
        end
        is_if_stall = 1'b0;
        tick();
        check_value("t2_rel_instr", if_id_instruc, mem_word(32'd8));
        check_value("t2_rel_nextpc", if_id_nextpc, 32'd9);
        check_value("t2_rel_addr", if_mem_addr, 32'd9);
        tick();
        check_value("t2_nextpc_a", if_id_nextpc, 32'd10);
        tick();
        check_value("t2_nextpc_b", if_id_nextpc, 32'd11);
        mem_en = 1'b0;
        tick();
        check_value("t2_drain", 32'(exp_q.size()), 32'd0);

        // 3: redirect while a 3-cycle fetch is outstanding
        mem_lat = 3; mem_en = 1'b1;
        id_if_selpcsource = 1'b1; id_if_selpctype = 2'b01; id_if_pcindex = 32'h40;
        push_exp(32'h40);
        #1;
        check_value("t3_addr0", if_mem_addr, 32'd11);
        tick();
        id_if_selpcsource = 1'b0;
        check_value("t3_redir_instr", if_id_instruc, NOP_INSTR);
        for (int i = 0; i < 3; i++) begin
            check_value("t3_daddr", if_mem_addr, 32'd11);
            check_value("t3_dreq", {31'd0, if_mem_req}, 32'd1);
            tick();
            check_value("t3_bubble", if_id_instruc, NOP_INSTR);
        end
        check_value("t3_new_addr", if_mem_addr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("t3_wait_instr", if_id_instruc, NOP_INSTR);
        end
        tick();
        check_value("t3_instr", if_id_instruc, mem_word(32'h40));
        check_value("t3_nextpc", if_id_nextpc, 32'h41);
        mem_en = 1'b0;

        // 4: redirect wins over an ack in the same cycle
        mem_lat = 0; mem_en = 1'b1;
        id_if_selpcsource = 1'b1; id_if_selpctype = 2'b00; id_if_pcimd2ext = 32'h10;
        push_exp(32'h10);
        tick();
        id_if_selpcsource = 1'b0;
        check_value("t4_instr_nop", if_id_instruc, NOP_INSTR);
        check_value("t4_addr", if_mem_addr, 32'h10);
        tick();
        check_value("t4_nextpc", if_id_nextpc, 32'h11);
        mem_en = 1'b0;

        // 5: no redirect while stalled; taken once the stall drops
        is_if_stall = 1'b1; id_if_selpcsource = 1'b1; id_if_selpctype = 2'b10; id_if_rega = 32'h99;
        push_exp(32'h99);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_value("t5_stall_addr", if_mem_addr, 32'h11);
            check_value("t5_stall_instr", if_id_instruc, mem_word(32'h10));
        end
        is_if_stall = 1'b0;
        tick();
        id_if_selpcsource = 1'b0;
        check_value("t5_redir_instr", if_id_instruc, NOP_INSTR);
        check_value("t5_daddr", if_mem_addr, 32'h11);
        mem_en = 1'b1;
        tick();
        check_value("t5_drop_instr", if_id_instruc, NOP_INSTR);
        check_value("t5_new_addr", if_mem_addr, 32'h99);
        tick();
        check_value("t5_nextpc", if_id_nextpc, 32'h9A);
        mem_en = 1'b0;

        // 6a: reset while in DISCARD
        id_if_selpcsource = 1'b1; id_if_selpctype = 2'b11;
        tick();
        id_if_selpcsource = 1'b0;
        check_value("t6_disc_addr", if_mem_addr, 32'h9A);
        reset = 1'b1;
        tick();
        check_value("t6a_instr", if_id_instruc, NOP_INSTR);
        check_value("t6a_nextpc", if_id_nextpc, 32'd0);
        check_value("t6a_req", {31'd0, if_mem_req}, 32'd0);
        reset = 1'b0;
        #1;
        check_value("t6a_addr", if_mem_addr, RESET_PC);
        check_value("t6a_req_on", {31'd0, if_mem_req}, 32'd1);

        // 6b: reset while in HOLD; the buffered word must never surface
        push_exp(32'd0);
        mem_en = 1'b1;
        tick();
        check_value("t6b_instr0", if_id_instruc, mem_word(32'd0));
        is_if_stall = 1'b1;
        tick();
        check_value("t6b_hold_req", {31'd0, if_mem_req}, 32'd0);
        check_value("t6b_hold_instr", if_id_instruc, mem_word(32'd0));
        reset = 1'b1;
        tick();
        check_value("t6b_instr", if_id_instruc, NOP_INSTR);
        check_value("t6b_nextpc", if_id_nextpc, 32'd0);
        reset = 1'b0; is_if_stall = 1'b0; mem_en = 1'b0;
        #1;
        check_value("t6b_addr", if_mem_addr, RESET_PC);
        check_value("t6b_req", {31'd0, if_mem_req}, 32'd1);
        tick();
        tick();
        check_value("t6b_no_leak", if_id_instruc, NOP_INSTR);

        // 7: exception vector, then PC wrap at the top of the address space
        mem_en = 1'b1;
        id_if_selpcsource = 1'b1; id_if_selpctype = 2'b11;
        tick();
        check_value("t7_exc_addr", if_mem_addr, EXC_VECTOR);
        id_if_selpctype = 2'b10; id_if_rega = 32'hFFFF_FFFF;
        push_exp(32'hFFFF_FFFF); push_exp(32'd0);
        tick();
        id_if_selpcsource = 1'b0;
        check_value("t7_top_addr", if_mem_addr, 32'hFFFF_FFFF);
        tick();
        check_value("t7_wrap_nextpc", if_id_nextpc, 32'd0);
        check_value("t7_wrap_addr", if_mem_addr, 32'd0);
        tick();
        check_value("t7_after_nextpc", if_id_nextpc, 32'd1);
        mem_en = 1'b0;
        tick();
        check_value("final_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
